int_to_fp_stream: RTL
=====================

Name: int_to_fp_stream

Overview:
- Upstream feeder for the floating-point array adder.
- Accepts an AXI-Stream of signed 32-bit integers and emits IEEE-754 single-precision values on an AXI-Stream master, ready to drive the adder's s00_axis slave port.
- 3-register pipeline with round-to-nearest-even; tlast is carried through.
- Checks frame length against SIZE and flags mismatches.

Parameters:
- SIZE, 10, number of elements per frame (one adder operand array).
- DATA_WIDTH, 32, stream width; only 32 is supported.

Ports:
- s00_axi_aclk  in  1  single clock, rising edge.
- s00_axi_areset  in  1  reset, synchronous, active-high.
- s00_axis_tdata  in  32  signed two's-complement integer.
- s00_axis_tvalid  in  1  input beat valid.
- s00_axis_tready  out  1  input beat accepted when tvalid & tready.
- s00_axis_tlast  in  1  last element of frame.
- m00_axis_tdata  out  32  fp32 result.
- m00_axis_tvalid  out  1  output beat valid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tlast  out  1  tlast of the corresponding input beat.
- m00_axis_tstrb  out  4  constant 4'hF.
- frame_err  out  1  sticky frame-length error.

Behaviour:
- Reset, sampled on the clock edge while s00_axi_areset=1:
  - all stage valids, m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata, frame_err and the input counter go to 0.
  - s00_axis_tready is 0 while reset is high.
  - Reset mid-frame discards all in-flight beats. No partial output follows reset.
- Pipeline:
  - Three registers: S1, S2 and OUT. OUT drives the m00 ports.
  - Global enable en = ~m00_axis_tvalid | m00_axis_tready.
  - s00_axis_tready = en (combinational).
  - When en=1 every stage shifts forward. Bubbles (valid=0) move like data.
  - When en=0 nothing moves. m00_axis_tdata, m00_axis_tvalid and m00_axis_tlast hold stable until the beat is taken.
- Latency: with no stall, a beat accepted at edge N is presented on m00 right after edge N+2.
- Throughput: 1 beat/cycle.
- S1:
  - sign = d[31].
  - mag = sign ? -d : d, as unsigned 32 bits. -2^31 gives 0x80000000.
  - zero = (d == 0).
  - Latch tlast.
- S2:
  - lz = leading-zero count of mag (0..31).
  - norm = mag << lz.
- OUT:
  - exp = 158 - lz.
  - mant = norm[30:8], guard g = norm[7], sticky s = |norm[6:0].
  - Round up iff g & (s | norm[8]).
  - If rounding carries out of the 23-bit mantissa: mant = 0, exp = exp + 1.
  - Result = {sign, exp[7:0], mant}.
  - zero input gives 0x00000000. A negative-zero encoding is never produced.
  - Overflow is impossible; the maximum exponent is 158.
- Frame check (input side):
  - cnt (0..SIZE-1) increments on each accepted beat.
  - cnt returns to 0 on an accepted beat with tlast=1, or on the beat where cnt == SIZE-1.
  - frame_err is set when an accepted beat has tlast=1 with cnt != SIZE-1, or tlast=0 with cnt == SIZE-1.
  - frame_err stays set until reset. Data still flows unchanged.
- Simultaneous input accept and output take in the same cycle are both honoured; no bubble is inserted.
- tvalid=1 and tready=0 on the input: the beat is held upstream and not counted.

Test Plan:
- Reset, then a 10-beat frame of 1..10 with tlast on beat 10 and m00_axis_tready=1:
  - outputs 0x3F800000, 0x40000000, 0x40400000, 0x40800000, 0x40A00000, 0x40C00000, 0x40E00000, 0x41000000, 0x41100000, 0x41200000.
  - tlast=1 only on the 10th output.
  - first output appears 2 edges after first accept.
  - frame_err=0.
- Sign and edge values 0, -1, -2^31, 0x7FFFFFFF -> 0x00000000, 0xBF800000, 0xCF000000, 0x4F000000.
- Rounding:
  - 16777217 -> 0x4B800000 (tie, even down).
  - 16777219 -> 0x4B800002 (tie, even up).
  - 16777221 -> 0x4B800002 (tie, even down).
  - 33554435 -> 0x4C000001 (above half, up).
- Backpressure: drive m00_axis_tready=0 for 5 cycles mid-frame.
  - m00_axis_tdata/tvalid/tlast hold stable.
  - s00_axis_tready drops to 0 once the output is occupied.
  - After release the full sequence arrives in order with no loss or duplication.
- Frame error:
  - tlast on beat 7 of SIZE=10 -> frame_err=1 after that edge and stays 1.
  - Data still converts correctly.
  - A second run with 10 beats and no tlast also sets frame_err.
- Reset mid-frame:
  - assert s00_axi_areset for 1 cycle after 4 accepted beats.
  - m00_axis_tvalid=0 and frame_err=0 the next cycle.
  - A subsequent clean 10-beat frame completes with frame_err=0 and tlast on beat 10.

Source files
------------

// File: rtl/int_to_fp_stream.sv
// int_to_fp_stream: signed int32 AXI-Stream to fp32 AXI-Stream, 3-stage RNE pipeline with frame-length check
module int_to_fp_stream #(
   parameter int SIZE       = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  s00_axi_aclk,
   input  logic                  s00_axi_areset,
   input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                  s00_axis_tvalid,
   output logic                  s00_axis_tready,
   input  logic                  s00_axis_tlast,
   output logic [DATA_WIDTH-1:0] m00_axis_tdata,
   output logic                  m00_axis_tvalid,
   input  logic                  m00_axis_tready,
   output logic                  m00_axis_tlast,
   output logic [3:0]            m00_axis_tstrb,
   output logic                  frame_err
);
   localparam int CW = SIZE > 1 ? $clog2(SIZE) : 1;
   localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
   logic en, acc;
   logic s1_v_q, s1_sign_q, s1_zero_q, s1_last_q;
   logic [31:0] s1_mag_q, mag_d;
   logic s2_v_q, s2_sign_q, s2_zero_q, s2_last_q;
   logic [4:0] s2_lz_q, lz_d;
   logic [31:0] s2_norm_q;
   logic out_v_q, out_last_q;
   logic [31:0] out_data_q, res_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic err_q, err_d;
   logic rnd;
   logic [23:0] mant_r;
   logic [7:0] exp_r;

   assign en = ~out_v_q | m00_axis_tready;
   assign s00_axis_tready = en & ~s00_axi_areset;
   assign acc = s00_axis_tvalid & s00_axis_tready;
   assign mag_d = s00_axis_tdata[31] ? -s00_axis_tdata : s00_axis_tdata;
   assign m00_axis_tdata = out_data_q;
   assign m00_axis_tvalid = out_v_q;
   assign m00_axis_tlast = out_last_q;
   assign m00_axis_tstrb = 4'hF;
   assign frame_err = err_q;

   // leading-zero count: the highest set bit is the last one to overwrite lz_d
   always_comb begin
      lz_d = 5'd0;
      for (int i = 0; i < 32; i++) if (s1_mag_q[i]) lz_d = 5'(31 - i);
   end

   // round-to-nearest-even on the normalised magnitude; a mantissa carry bumps the exponent
   always_comb begin
      rnd = s2_norm_q[7] & (|s2_norm_q[6:0] | s2_norm_q[8]);
      mant_r = {1'b0, s2_norm_q[30:8]} + 24'(rnd);
      exp_r = 8'(158 - 32'(s2_lz_q)) + 8'(mant_r[23]);
      res_d = s2_zero_q ? 32'd0 : {s2_sign_q, exp_r, mant_r[22:0]};
   end

   // frame counter wraps on tlast or at SIZE-1; an error is any disagreement between the two
   always_comb begin
      cnt_d = acc ? ((s00_axis_tlast | (cnt_q == LAST)) ? '0 : cnt_q + CW'(1)) : cnt_q;
      err_d = err_q | (acc & (s00_axis_tlast ^ (cnt_q == LAST)));
   end

   // pipeline registers advance together under the global enable; frame state updates on accept
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         {s1_v_q, s1_sign_q, s1_zero_q, s1_last_q, s1_mag_q} <= '0;
         {s2_v_q, s2_sign_q, s2_zero_q, s2_last_q, s2_lz_q, s2_norm_q} <= '0;
         {out_v_q, out_last_q, out_data_q} <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (en) begin
            s1_v_q <= acc;
            s1_sign_q <= s00_axis_tdata[31];
            s1_zero_q <= s00_axis_tdata == 32'd0;
            s1_last_q <= s00_axis_tlast;
            s1_mag_q <= mag_d;
            s2_v_q <= s1_v_q;
            s2_sign_q <= s1_sign_q;
            s2_zero_q <= s1_zero_q;
            s2_last_q <= s1_last_q;
            s2_lz_q <= lz_d;
            s2_norm_q <= s1_mag_q << lz_d;
            out_v_q <= s2_v_q;
            out_last_q <= s2_last_q;
            out_data_q <= res_d;
         end
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
endmodule
